// File: rtl/store_packer_pkg.sv
// Shared types for the store packer: request size encoding and FSM states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package store_packer_pkg;

    // Store width as carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Packer control states: waiting for a request, first beat, second (split) beat.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    // True when the store crosses a word boundary and so needs two beats.
    function automatic logic is_misaligned(input logic [1:0] off, input size_e size);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = (off == 2'd3);
            SZ_WORD: mis = (off != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Lane steering for one store: 8-bit lane mask spanning two words plus byte-rotated data.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module store_lane_gen
    import store_packer_pkg::*;
(
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic [31:0] data,
    output logic [7:0]  mask,
    output logic [31:0] rot_data
);

    logic [3:0] base;

    // Base byte mask for the store width, shifted up to the starting byte lane.
    always_comb begin
        base = 4'b0000;
        case (size)
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            SZ_WORD: base = 4'b1111;
            default: base = 4'b0000;
        endcase
        mask = {4'b0000, base} << off;
    end

    // Rotate left by whole bytes so data byte 0 lands on lane 'off'; bytes that
    // wrap past lane 3 are the ones the second beat writes at lanes 0..2.
    always_comb begin
        rot_data = data;
        case (off)
            2'd0: rot_data = data;
            2'd1: rot_data = {data[23:0], data[31:24]};
            2'd2: rot_data = {data[15:0], data[31:16]};
            2'd3: rot_data = {data[7:0],  data[31:8]};
            default: rot_data = data;
        endcase
    end

endmodule

// File: rtl/store_packer.sv
// Packs SB/SH/SW stores into word-aligned memory beats, splitting word-crossing stores in two.
// Latency: first beat valid the cycle after accept; all mem_* outputs come from flops.
// Backpressure: beats hold stable until mem_ready; req_ready only while idle.
module store_packer
    import store_packer_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    output logic        err
);

    size_e       req_sz;
    logic [7:0]  lane_mask;
    logic [31:0] lane_data;
    logic        bad_req;

    state_e      state;
    state_e      state_nxt;
    logic        load_req;
    logic        load_hi;
    logic        reject;

    logic [29:0] word_q;
    logic [3:0]  hi_strb_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_strb_q;
    logic        err_q;

    assign req_sz = size_e'(req_size);

    store_lane_gen u_lane_gen (
        .off      (req_addr[1:0]),
        .size     (req_sz),
        .data     (req_data),
        .mask     (lane_mask),
        .rot_data (lane_data)
    );

    // Requests that are consumed without issuing any beat.
    always_comb begin
        bad_req = (req_sz == SZ_ILL) ||
                  (!ALLOW_MISALIGNED && is_misaligned(req_addr[1:0], req_sz));
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath load strobes.
    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        load_hi   = 1'b0;
        reject    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (bad_req) begin
                        reject = 1'b1;
                    end else begin
                        load_req  = 1'b1;
                        state_nxt = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
                    if (hi_strb_q != 4'b0000) begin
                        load_hi   = 1'b1;
                        state_nxt = ST_BEAT1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_BEAT1: begin
                if (mem_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Beat registers: loaded on accept, retargeted to the next word for the
    // second beat, otherwise held so a stalled beat stays stable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q      <= '0;
            hi_strb_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_strb_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_valid_q <= (state_nxt != ST_IDLE);
            err_q       <= reject;
            if (load_req) begin
                word_q      <= req_addr[31:2];
                hi_strb_q   <= lane_mask[7:4];
                mem_addr_q  <= {req_addr[31:2], 2'b00};
                mem_wdata_q <= lane_data;
                mem_strb_q  <= lane_mask[3:0];
            end else if (load_hi) begin
                mem_addr_q  <= {word_q + 30'd1, 2'b00};
                mem_strb_q  <= hi_strb_q;
            end
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_strb  = mem_strb_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_packer.sv
// Randomized and directed check of store_packer against a byte-level store model.
// Latency: n/a (testbench).
// Backpressure: drives random and scripted mem_ready stalls.
module tb_store_packer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_ready = 1'b0;

    logic        req_ready, mem_valid, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_strb;
    logic        req_ready0, mem_valid0, err0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [3:0]  mem_strb0;

    int errors = 0;
    int checks = 0;

    // Model outputs for the current store (splitting allowed).
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_strb [2];
    logic [31:0] exp_wdata;
    int          exp_n;
    bit          exp_err;
    bit          exp_misal;

    // Beats observed from the splitting instance.
    logic [31:0] obs_addr  [2];
    logic [31:0] obs_wdata [2];
    logic [3:0]  obs_strb  [2];
    int          ready_cycle;

    store_packer #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .err(err)
    );

    store_packer #(.ALLOW_MISALIGNED(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready0),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid0), .mem_ready(mem_ready),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_strb(mem_strb0),
        .err(err0)
    );

    always #5 clock = ~clock;

    // Byte-level model: each store byte goes to address addr+i; bytes in the
    // starting word form beat 0, bytes in the following word form beat 1.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int          nb;
        int          lane;
        logic [31:0] ba;
        logic [3:0]  s0, s1;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        exp_err = (sz == 2'd3);
        s0 = 4'b0000;
        s1 = 4'b0000;
        for (int i = 0; i < nb; i++) begin
            ba = a + 32'(i);
            if (ba[31:2] == a[31:2]) s0[ba[1:0]] = 1'b1;
            else                     s1[ba[1:0]] = 1'b1;
        end
        exp_strb[0] = s0;
        exp_strb[1] = s1;
        exp_addr[0] = {a[31:2], 2'b00};
        exp_addr[1] = exp_addr[0] + 32'd4;
        exp_n = (nb == 0) ? 0 : (s1 != 4'b0000) ? 2 : 1;
        exp_misal = (exp_n == 2);
        for (int j = 0; j < 4; j++) begin
            lane = (j + int'(a[1:0])) % 4;
            exp_wdata[lane*8 +: 8] = d[j*8 +: 8];
        end
    endtask

    // Issue one store (caller is at a negedge with the DUT idle) and follow it
    // to completion. mode: 0 always ready, 1 random ready, 2 stall beat0 x3.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input int mode);
        int          k, k0, stalls, stall_b0, exp_n0;
        bit          prev_stall;
        logic [31:0] h_addr, h_wdata;
        logic [3:0]  h_strb;
        model(a, d, sz);
        exp_n0 = (exp_err || exp_misal) ? 0 : exp_n;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_before_send: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom);
        k = 0; k0 = 0; stalls = 0; stall_b0 = 0; prev_stall = 1'b0;
        h_addr = '0; h_wdata = '0; h_strb = '0;
        ready_cycle = -1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (cyc == 1) begin
                checks++;
                if (err !== exp_err) begin
                    errors++;
                    $display("FAIL err_pulse: got %b want %b (addr %h size %0d)", err, exp_err, a, sz);
                end
                checks++;
                if (err0 !== (exp_err || exp_misal)) begin
                    errors++;
                    $display("FAIL err_strict: got %b want %b (addr %h size %0d)", err0, exp_err || exp_misal, a, sz);
                end
                checks++;
                if (mem_valid !== (exp_n > 0)) begin
                    errors++;
                    $display("FAIL first_beat_latency: mem_valid %b want %b", mem_valid, exp_n > 0);
                end
            end else begin
                checks++;
                if (err !== 1'b0 || err0 !== 1'b0) begin
                    errors++;
                    $display("FAIL err_width: err %b err0 %b want 0 at cycle %0d", err, err0, cyc);
                end
            end
            if (req_ready === 1'b1) begin
                ready_cycle = cyc;
                break;
            end
            if (mem_valid && prev_stall) begin
                checks++;
                if (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_strb !== h_strb) begin
                    errors++;
                    $display("FAIL stall_stable: got %h/%h/%b want %h/%h/%b", mem_addr, mem_wdata, mem_strb, h_addr, h_wdata, h_strb);
                end
            end
            h_addr = mem_addr; h_wdata = mem_wdata; h_strb = mem_strb;
            case (mode)
                0: mem_ready = 1'b1;
                1: mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = !(mem_valid && k == 0 && stall_b0 < 3);
            endcase
            if (mode == 2 && mem_valid && k == 0 && stall_b0 < 3) stall_b0++;
            prev_stall = mem_valid && !mem_ready;
            if (prev_stall) stalls++;
            if (mem_valid && mem_ready) begin
                checks++;
                if (k >= exp_n) begin
                    errors++;
                    $display("FAIL extra_beat: beat %0d addr %h beyond %0d expected", k, mem_addr, exp_n);
                end else if (mem_addr !== exp_addr[k] || mem_wdata !== exp_wdata || mem_strb !== exp_strb[k]) begin
                    errors++;
                    $display("FAIL beat%0d: got %h/%h/%b want %h/%h/%b", k, mem_addr, mem_wdata, mem_strb, exp_addr[k], exp_wdata, exp_strb[k]);
                end
                if (k < 2) begin
                    obs_addr[k] = mem_addr; obs_wdata[k] = mem_wdata; obs_strb[k] = mem_strb;
                end
                k++;
            end
            if (mem_valid0 && mem_ready) begin
                checks++;
                if (k0 >= exp_n0) begin
                    errors++;
                    $display("FAIL strict_extra_beat: beat %0d addr %h beyond %0d expected", k0, mem_addr0, exp_n0);
                end else if (mem_addr0 !== exp_addr[k0] || mem_wdata0 !== exp_wdata || mem_strb0 !== exp_strb[k0]) begin
                    errors++;
                    $display("FAIL strict_beat%0d: got %h/%h/%b want %h/%h/%b", k0, mem_addr0, mem_wdata0, mem_strb0, exp_addr[k0], exp_wdata, exp_strb[k0]);
                end
                k0++;
            end
            @(negedge clock);
        end
        checks++;
        if (k !== exp_n) begin
            errors++;
            $display("FAIL beat_count: got %0d want %0d (addr %h size %0d)", k, exp_n, a, sz);
        end
        checks++;
        if (k0 !== exp_n0) begin
            errors++;
            $display("FAIL strict_beat_count: got %0d want %0d", k0, exp_n0);
        end
        checks++;
        if (ready_cycle !== exp_n + 1 + stalls) begin
            errors++;
            $display("FAIL ready_return: got cycle %0d want %0d", ready_cycle, exp_n + 1 + stalls);
        end
    endtask

    // Idle gap with random mem_ready; no beat may appear.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            checks++;
            if (mem_valid !== 1'b0 || mem_valid0 !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_beat: mem_valid %b mem_valid0 %b want 0", mem_valid, mem_valid0);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (mem_valid !== 1'b0 || err !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_strb !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v%b e%b %h/%h/%b want all zero", mem_valid, err, mem_addr, mem_wdata, mem_strb);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready %b mem_valid %b want 1/0", req_ready, mem_valid);
        end
    endtask

    task automatic test_sw_aligned();
        send(32'h100, 32'hDEADBEEF, 2'd2, 0);
        checks++;
        if (obs_addr[0] !== 32'h100 || obs_wdata[0] !== 32'hDEADBEEF || obs_strb[0] !== 4'b1111 || ready_cycle !== 2) begin
            errors++;
            $display("FAIL sw_aligned: got %h/%h/%b ready %0d want 00000100/deadbeef/1111 ready 2", obs_addr[0], obs_wdata[0], obs_strb[0], ready_cycle);
        end
    endtask

    task automatic test_sb();
        send(32'h203, 32'h000000A5, 2'd0, 0);
        checks++;
        if (obs_addr[0] !== 32'h200 || obs_wdata[0][31:24] !== 8'hA5 || obs_strb[0] !== 4'b1000) begin
            errors++;
            $display("FAIL sb_lane3: got %h/%h/%b want 00000200/a5xxxxxx/1000", obs_addr[0], obs_wdata[0], obs_strb[0]);
        end
    endtask

    task automatic test_sh_split();
        send(32'h103, 32'h00001234, 2'd1, 0);
        checks++;
        if (obs_addr[0] !== 32'h100 || obs_strb[0] !== 4'b1000 || obs_wdata[0][31:24] !== 8'h34 ||
            obs_addr[1] !== 32'h104 || obs_strb[1] !== 4'b0001 || obs_wdata[1][7:0] !== 8'h12) begin
            errors++;
            $display("FAIL sh_split: got %h/%b/%h then %h/%b/%h", obs_addr[0], obs_strb[0], obs_wdata[0], obs_addr[1], obs_strb[1], obs_wdata[1]);
        end
    endtask

    task automatic test_stall();
        send(32'h102, 32'h11223344, 2'd2, 2);
        checks++;
        if (obs_addr[0] !== 32'h100 || obs_strb[0] !== 4'b1100 || obs_addr[1] !== 32'h104 || obs_strb[1] !== 4'b0011) begin
            errors++;
            $display("FAIL sw_split_stall: got %h/%b then %h/%b want 100/1100 then 104/0011", obs_addr[0], obs_strb[0], obs_addr[1], obs_strb[1]);
        end
    endtask

    task automatic test_errors();
        send(32'h100, 32'hCAFEF00D, 2'd3, 0);
        send(32'h101, 32'h55667788, 2'd2, 1);
    endtask

    task automatic test_wrap();
        send(32'hFFFFFFFF, 32'hA1B2C3D4, 2'd2, 0);
        checks++;
        if (obs_addr[0] !== 32'hFFFFFFFC || obs_addr[1] !== 32'h00000000) begin
            errors++;
            $display("FAIL addr_wrap: got %h then %h want fffffffc then 00000000", obs_addr[0], obs_addr[1]);
        end
    endtask

    task automatic test_back_to_back();
        send(32'h300, 32'h01020304, 2'd2, 0);
        send(32'h305, 32'h0000BEEF, 2'd1, 0);
        send(32'h30B, 32'h12345678, 2'd1, 0);
        send(32'h30E, 32'h9ABCDEF0, 2'd2, 0);
    endtask

    task automatic test_reset_mid_beat();
        mem_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h103; req_data = 32'h00001234; req_size = 2'd1;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_valid !== 1'b1 || mem_strb !== 4'b0001 || mem_addr !== 32'h104) begin
            errors++;
            $display("FAIL reach_beat1: got v%b %h/%b want 1 00000104/0001", mem_valid, mem_addr, mem_strb);
        end
        mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || mem_strb !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_beat: got v%b %h/%h/%b want 0 and zeros", mem_valid, mem_addr, mem_wdata, mem_strb);
        end
        @(negedge clock);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_reset_idle: mem_valid %b req_ready %b want 0/1", mem_valid, req_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if (n % 8 == 0) a[31:4] = 28'hFFFFFFF;
            send(a, $urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            idle_cycles(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_sw_aligned();
        test_sb();
        test_sh_split();
        test_stall();
        test_errors();
        test_wrap();
        test_back_to_back();
        test_reset_mid_beat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/store_packer.md
STORE_PACKER -- requirements
Module: store_packer

Interface
REQ-001 Parameter ALLOW_MISALIGNED, default 1: 1 splits a misaligned store into two memory beats; 0 rejects it with err.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  store request present.
REQ-005 req_ready  out  1  block accepts a request this cycle.
REQ-006 req_addr  in  32  byte address of the store.
REQ-007 req_data  in  32  rs2 value; low byte or halfword holds the store data for narrow stores.
REQ-008 req_size  in  2  00 byte (SB), 01 half (SH), 10 word (SW), 11 illegal.
REQ-009 mem_valid  out  1  memory write beat valid.
REQ-010 mem_ready  in  1  memory accepts the beat.
REQ-011 mem_addr  out  32  word-aligned beat address; bits [1:0] always 0.
REQ-012 mem_wdata  out  32  lane-aligned write data.
REQ-013 mem_strb  out  4  byte-lane write enables.
REQ-014 err  out  1  one-cycle pulse for an illegal size, or for a misaligned store when ALLOW_MISALIGNED=0.

Function
REQ-015 A request is accepted when req_valid && req_ready; req_ready is 1 only in state IDLE.
REQ-016 States: IDLE, BEAT0, BEAT1.
REQ-017 On accept, capture the following into registers: off=addr[1:0], word=addr[31:2], rotated data = req_data rotated left by 8*off, and size.
REQ-018 Legal accept: next state BEAT0, with mem_valid=1 in the cycle after accept (latency 1); no combinational path from req_* to mem_*.
REQ-019 Lane mask before splitting: byte 0001, half 0011, word 1111, shifted left by off over 8 bits; low 4 bits form beat0 strb, high 4 bits form beat1 strb.
REQ-020 BEAT0: mem_addr={word,2'b00}, strb=low mask; on mem_ready, go to BEAT1 if high mask is nonzero, else IDLE.
REQ-021 BEAT1: mem_addr={word+1,2'b00}, same rotated wdata, strb=high mask; on mem_ready, go to IDLE.
REQ-022 word+1 wraps modulo 2^30 (address 0xFFFFFFFF splits to 0xFFFFFFFC then 0x00000000).
REQ-023 While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_strb are held stable.
REQ-024 mem_valid is 0 in IDLE; all beat outputs are registered.
REQ-025 Illegal size, or misaligned (half with off=3, or word with off!=0) when ALLOW_MISALIGNED=0: accepted, err=1 in the next cycle, no beat issued, remain IDLE.
REQ-026 Back-to-back: a new request is accepted no earlier than the cycle after the final beat handshake; maximum throughput is one request per 2 cycles (aligned) or per 3 cycles (split).
REQ-027 mem_ready while mem_valid=0 is ignored.

Reset
REQ-028 reset_n low forces IDLE, mem_valid=0, err=0, mem_addr=0, mem_wdata=0, mem_strb=0, and req_ready=1 after release.
REQ-029 Reset asserted mid-beat abandons the store; no beat is issued after deassertion.

Structure
REQ-030 Shared package holds the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL) and the state enum.
REQ-031 One sub-module, store_lane_gen: combinational; takes off and size and returns the 8-bit lane mask and the rotated data.

Verification
REQ-032 SW addr 0x100 data 0xDEADBEEF, mem_ready=1 -> one beat: addr 0x100, wdata 0xDEADBEEF, strb 1111; req_ready back to 1 two cycles after accept.
REQ-033 SB addr 0x203 data 0x000000A5 -> one beat: addr 0x200, wdata 0xA5xxxxxx (byte 3=A5), strb 1000.
REQ-034 SH addr 0x103 data 0x00001234, ALLOW_MISALIGNED=1 -> beat0: addr 0x100, strb 1000, byte3=0x34; then beat1: addr 0x104, strb 0001, byte0=0x12.
REQ-035 SW addr 0x102 data 0x11223344 with mem_ready low for 3 cycles on beat0 -> beat0 held stable (addr 0x100, strb 1100); beat1: addr 0x104, strb 0011.
REQ-036 req_size=11, or SW addr 0x101 with ALLOW_MISALIGNED=0 -> err pulses for 1 cycle, mem_valid stays 0.
REQ-037 reset_n low during BEAT1 of a split store -> mem_valid=0 immediately; after release the state is IDLE with no further beat.
